id_scoreboard_regfile: RTL and testbench

- Parametrised successor to the decode-stage register file and hazard logic.
- Combines a multi-read-port register file, a per-register pending-write scoreboard and issue-stall generation.
- Sits in the ID stage: decode presents source and destination addresses; WB presents write-backs.
- Generalises the fixed 16x32, two-source, single-in-flight arrangement to N read ports and multiple in-flight writes per register.

---
 rtl/id_scoreboard_regfile.sv | 109 ++++++++++
 tb/tb_id_scoreboard_regfile.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/id_scoreboard_regfile.sv
// ID-stage register file with per-register pending-write counters and issue-stall logic.
// Define REGFILE_BYPASS_EN to forward write-back data to the read ports in the same cycle.
module id_scoreboard_regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int NUM_RD = 2,
   parameter int CNT_W  = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   input  logic [NUM_RD-1:0]          rd_use,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   input  logic                       issue_valid,
   input  logic                       issue_wb_en,
   input  logic [ADDR_W-1:0]          issue_dest,
   output logic                       stall,
   input  logic                       wb_en,
   input  logic [ADDR_W-1:0]          wb_dest,
   input  logic [DATA_W-1:0]          wb_data,
   output logic [(2**ADDR_W)-1:0]     busy_vec,
   output logic                       err_underflow
);

   localparam int NUM_REGS = 2**ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic [CNT_W-1:0]  cnt_q  [NUM_REGS];
   logic [CNT_W-1:0]  cnt_d  [NUM_REGS];
   logic              err_q;
   logic              err_d;

   logic [ADDR_W-1:0]   port_addr [NUM_RD];
   logic [NUM_RD-1:0]   resolved;
   logic [NUM_RD-1:0]   raw_hazard;
   logic                sat_hazard;
   logic                issue_fire;
   logic [NUM_REGS-1:0] inc_vec;
   logic [NUM_REGS-1:0] dec_vec;

   for (genvar i = 0; i < NUM_RD; i++) begin : g_port
      assign port_addr[i] = rd_addr[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
      logic port_hit;
      assign port_hit = wb_en & (wb_dest == port_addr[i]);
      assign rd_data[i*DATA_W +: DATA_W] = port_hit ? wb_data : regs_q[port_addr[i]];
      // The final outstanding write arriving now is forwarded, so the consumer may issue.
      assign resolved[i] = port_hit & (cnt_q[port_addr[i]] == CNT_W'(1));
`else
      assign rd_data[i*DATA_W +: DATA_W] = regs_q[port_addr[i]];
      assign resolved[i] = 1'b0;
`endif
      assign raw_hazard[i] = issue_valid & rd_use[i] &
                             (cnt_q[port_addr[i]] != '0) & ~resolved[i];
   end

   // A write-back to the same destination frees a slot, so a full counter need not block.
   assign sat_hazard = issue_valid & issue_wb_en & (cnt_q[issue_dest] == CNT_MAX) &
                       ~(wb_en & (wb_dest == issue_dest));
   assign stall      = (|raw_hazard) | sat_hazard;
   assign issue_fire = issue_valid & ~stall;

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      assign inc_vec[r]  = issue_fire & issue_wb_en & (issue_dest == ADDR_W'(r));
      assign dec_vec[r]  = wb_en & (wb_dest == ADDR_W'(r));
      assign busy_vec[r] = |cnt_q[r];
   end

   always_comb begin
      err_d = err_q;
      for (int r = 0; r < NUM_REGS; r++) begin
         regs_d[r] = regs_q[r];
         cnt_d[r]  = cnt_q[r];
         if (dec_vec[r]) begin
            regs_d[r] = wb_data;
         end
         case ({inc_vec[r], dec_vec[r]})
            2'b10: cnt_d[r] = cnt_q[r] + CNT_W'(1);
            2'b01: begin
               if (cnt_q[r] != '0) begin
                  cnt_d[r] = cnt_q[r] - CNT_W'(1);
               end else begin
                  err_d = 1'b1;
               end
            end
            default: cnt_d[r] = cnt_q[r];
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= '0;
            cnt_q[r]  <= '0;
         end
         err_q <= 1'b0;
      end else begin
         regs_q <= regs_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign err_underflow = err_q;

endmodule

// File: tb/tb_id_scoreboard_regfile.sv
// Directed bench for id_scoreboard_regfile: expectations are queued as stimulus is driven
// and popped when the DUT outputs are sampled.
module tb_id_scoreboard_regfile;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 4;
   localparam int NUM_RD = 2;
   localparam int CNT_W  = 2;

   logic                     clk;
   logic                     rst;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD-1:0]        rd_use;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic                     issue_valid;
   logic                     issue_wb_en;
   logic [ADDR_W-1:0]        issue_dest;
   logic                     stall;
   logic                     wb_en;
   logic [ADDR_W-1:0]        wb_dest;
   logic [DATA_W-1:0]        wb_data;
   logic [15:0]              busy_vec;
   logic                     err_underflow;

   int compared   = 0;
   int mismatched = 0;

   logic [63:0] expQ[$];
   string       tagQ[$];

   id_scoreboard_regfile #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_use(rd_use), .rd_data(rd_data),
      .issue_valid(issue_valid), .issue_wb_en(issue_wb_en), .issue_dest(issue_dest),
      .stall(stall), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
      .busy_vec(busy_vec), .err_underflow(err_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic expectVal(input string tag, input logic [63:0] exp);
      tagQ.push_back(tag);
      expQ.push_back(exp);
   endtask

   task automatic checkOutput(input logic [63:0] obs);
      logic [63:0] exp;
      string       tag;
      compared++;
      if (expQ.size() == 0) begin
         mismatched++;
         $error("[TB] FAIL scoreboard_empty observed=%0h expected=none", obs);
      end else begin
         exp = expQ.pop_front();
         tag = tagQ.pop_front();
         assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         end
      end
   endtask

   task automatic applyStimulus(input logic iv, input logic iwb, input logic [3:0] idest,
                                input logic [3:0] a0, input logic [3:0] a1, input logic [1:0] use_,
                                input logic we, input logic [3:0] wd, input logic [31:0] wdat);
      issue_valid = iv;
      issue_wb_en = iwb;
      issue_dest  = idest;
      rd_addr     = {a1, a0};
      rd_use      = use_;
      wb_en       = we;
      wb_dest     = wd;
      wb_data     = wdat;
   endtask

   task automatic stepClk;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(0, 0, 4'd0, 4'd3, 4'd7, 2'b00, 0, 4'd0, 32'h0);
      #2;
      // Reset state
      expectVal("rst_rd0", 0); expectVal("rst_rd1", 0); expectVal("rst_stall", 0);
      expectVal("rst_busy", 0); expectVal("rst_err", 0);
      checkOutput(64'(rd_data[31:0])); checkOutput(64'(rd_data[63:32]));
      checkOutput(64'(stall)); checkOutput(64'(busy_vec)); checkOutput(64'(err_underflow));

      @(negedge clk);
      rst = 1'b0;

      // RAW stall and release on r5
      applyStimulus(1, 1, 4'd5, 4'd0, 4'd0, 2'b00, 0, 4'd0, 32'h0);
      expectVal("issue5_stall", 0);
      #1 checkOutput(64'(stall));
      stepClk();
      applyStimulus(1, 0, 4'd0, 4'd5, 4'd0, 2'b01, 0, 4'd0, 32'h0);
      expectVal("raw5_stall", 1); expectVal("raw5_busy", 1);
      #1 checkOutput(64'(stall)); checkOutput(64'(busy_vec[5]));
      applyStimulus(1, 0, 4'd0, 4'd5, 4'd0, 2'b01, 1, 4'd5, 32'hDEADBEEF);
`ifdef REGFILE_BYPASS_EN
      expectVal("wb5_stall", 0); expectVal("wb5_rd0", 64'hDEADBEEF);
      #1 checkOutput(64'(stall)); checkOutput(64'(rd_data[31:0]));
`else
      expectVal("wb5_stall", 1); expectVal("wb5_rd0", 0);
      #1 checkOutput(64'(stall)); checkOutput(64'(rd_data[31:0]));
`endif
      stepClk();
      applyStimulus(1, 0, 4'd0, 4'd5, 4'd0, 2'b01, 0, 4'd0, 32'h0);
      expectVal("after5_stall", 0); expectVal("after5_rd0", 64'hDEADBEEF); expectVal("after5_busy", 0);
      #1 checkOutput(64'(stall)); checkOutput(64'(rd_data[31:0])); checkOutput(64'(busy_vec[5]));
      stepClk();

      // Unused operand does not stall
      applyStimulus(1, 1, 4'd5, 4'd0, 4'd0, 2'b00, 0, 4'd0, 32'h0);
      stepClk();
      applyStimulus(1, 0, 4'd0, 4'd0, 4'd5, 2'b01, 0, 4'd0, 32'h0);
      expectVal("unused_stall", 0);
      #1 checkOutput(64'(stall));
      applyStimulus(1, 0, 4'd0, 4'd0, 4'd5, 2'b11, 0, 4'd0, 32'h0);
      expectVal("used1_stall", 1);
      #1 checkOutput(64'(stall));
      applyStimulus(0, 0, 4'd0, 4'd0, 4'd5, 2'b11, 0, 4'd0, 32'h0);
      expectVal("novalid_stall", 0);
      #1 checkOutput(64'(stall));
      applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 2'b00, 1, 4'd5, 32'h11);
      stepClk();

      // Multiple in-flight writes and saturation on r9
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1, 1, 4'd9, 4'd0, 4'd0, 2'b00, 0, 4'd0, 32'h0);
         expectVal($sformatf("fill9_%0d_stall", k), 0);
         #1 checkOutput(64'(stall));
         stepClk();
      end
      applyStimulus(1, 1, 4'd9, 4'd0, 4'd0, 2'b00, 0, 4'd0, 32'h0);
      expectVal("sat9_busy", 1); expectVal("sat9_stall", 1);
      #1 checkOutput(64'(busy_vec[9])); checkOutput(64'(stall));
      applyStimulus(1, 1, 4'd9, 4'd0, 4'd0, 2'b00, 1, 4'd9, 32'h99);
      expectVal("sat9_wb_stall", 0);
      #1 checkOutput(64'(stall));
      stepClk();
      applyStimulus(1, 1, 4'd9, 4'd9, 4'd0, 2'b00, 0, 4'd0, 32'h0);
      expectVal("sat9_still_full", 1); expectVal("sat9_rd0", 64'h99);
      #1 checkOutput(64'(stall)); checkOutput(64'(rd_data[31:0]));
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 0, 4'd0, 4'd9, 4'd0, 2'b00, 1, 4'd9, 32'h99);
         stepClk();
      end
      expectVal("drain9_busy", 0); expectVal("drain9_err", 0);
      #1 checkOutput(64'(busy_vec[9])); checkOutput(64'(err_underflow));

      // Simultaneous increment and decrement on r2
      applyStimulus(1, 1, 4'd2, 4'd0, 4'd0, 2'b00, 0, 4'd0, 32'h0);
      stepClk();
      applyStimulus(1, 1, 4'd2, 4'd0, 4'd0, 2'b00, 1, 4'd2, 32'h22222222);
      stepClk();
      applyStimulus(0, 0, 4'd0, 4'd2, 4'd0, 2'b00, 0, 4'd0, 32'h0);
      expectVal("incdec2_busy", 1); expectVal("incdec2_rd0", 64'h22222222);
      #1 checkOutput(64'(busy_vec[2])); checkOutput(64'(rd_data[31:0]));
      applyStimulus(1, 0, 4'd0, 4'd2, 4'd0, 2'b01, 0, 4'd0, 32'h0);
      expectVal("incdec2_raw", 1);
      #1 checkOutput(64'(stall));
      applyStimulus(0, 0, 4'd0, 4'd2, 4'd0, 2'b00, 1, 4'd2, 32'h22222222);
      stepClk();
      expectVal("drain2_busy", 0);
      #1 checkOutput(64'(busy_vec[2]));

      // Underflow on r4
      applyStimulus(0, 0, 4'd0, 4'd4, 4'd2, 2'b00, 1, 4'd4, 32'h44);
      expectVal("pre_uf_err", 0);
      #1 checkOutput(64'(err_underflow));
      stepClk();
      applyStimulus(0, 0, 4'd0, 4'd4, 4'd2, 2'b00, 0, 4'd0, 32'h0);
      expectVal("uf_err", 1); expectVal("uf_rd0", 64'h44); expectVal("uf_busy4", 0);
      #1 checkOutput(64'(err_underflow)); checkOutput(64'(rd_data[31:0])); checkOutput(64'(busy_vec[4]));

      // Mid-cycle async reset with a pending write to r6 and a dependent instruction
      applyStimulus(1, 1, 4'd6, 4'd0, 4'd0, 2'b00, 0, 4'd0, 32'h0);
      stepClk();
      applyStimulus(1, 0, 4'd0, 4'd6, 4'd2, 2'b01, 0, 4'd0, 32'h0);
      expectVal("pre_rst_stall", 1);
      #1 checkOutput(64'(stall));
      applyStimulus(1, 0, 4'd0, 4'd4, 4'd2, 2'b00, 0, 4'd0, 32'h0);
      #1 rst = 1'b1;
      applyStimulus(1, 0, 4'd0, 4'd6, 4'd4, 2'b01, 0, 4'd0, 32'h0);
      expectVal("arst_err", 0); expectVal("arst_rd1_r4", 0); expectVal("arst_busy", 0);
      expectVal("arst_stall", 0);
      #1 checkOutput(64'(err_underflow)); checkOutput(64'(rd_data[63:32]));
      checkOutput(64'(busy_vec)); checkOutput(64'(stall));
      applyStimulus(0, 0, 4'd0, 4'd2, 4'd9, 2'b00, 0, 4'd0, 32'h0);
      expectVal("arst_rd0_r2", 0); expectVal("arst_rd1_r9", 0);
      #1 checkOutput(64'(rd_data[31:0])); checkOutput(64'(rd_data[63:32]));

      if (expQ.size() != 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL scoreboard_leftover observed=%0d expected=0", expQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
